opn_bus_queue: RTL and testbench
================================

OPN_BUS_QUEUE -- requirements
Module: opn_bus_queue

Interface
REQ-001 Parameter DEPTH, default 8, write-queue entries (power of two, 2..64).
REQ-002 Parameter AWAIT, default 17, cen ticks of recovery after an address-port write (0..255).
REQ-003 Parameter DWAIT, default 83, cen ticks of recovery after a data-port write (0..255).
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cen  in  1  clock enable shared with the sound chip; all chip-side timing counts cen ticks.
REQ-007 cpu_wr  in  1  one-clk write request; pushes {cpu_addr, cpu_din}.
REQ-008 cpu_rd  in  1  one-clk read request for the port selected by cpu_addr.
REQ-009 cpu_addr  in  1  port select: 0 = address/status, 1 = data.
REQ-010 cpu_din  in  8  write data.
REQ-011 cpu_dout  out  8  captured read data.
REQ-012 cpu_rd_valid  out  1  one-clk pulse when cpu_dout is updated.
REQ-013 cpu_full  out  1  queue holds DEPTH entries.
REQ-014 cpu_ovf  out  1  sticky: a write was dropped.
REQ-015 level  out  7  current queue occupancy, 0..DEPTH.
REQ-016 opn_addr  out  1  chip address pin.
REQ-017 opn_din  out  8  chip data-in bus.
REQ-018 opn_cs_n  out  1  chip select, active low.
REQ-019 opn_wr_n  out  1  chip write strobe, active low.
REQ-020 opn_dout  in  8  chip data-out bus.

Function
REQ-021 Queue: FIFO of {addr, data}; push on any clk edge with cpu_wr=1 and level<DEPTH; level and cpu_full are registered.
REQ-022 Push with level==DEPTH: entry dropped, cpu_ovf set, even if a pop occurs in the same clk.
REQ-023 Simultaneous push and pop with level<DEPTH: both happen; level unchanged.
REQ-024 FSM states: IDLE, WR, WAIT, RD.
REQ-025 IDLE, cen=1, level>0: pop head, drive opn_addr/opn_din, set opn_cs_n=0 and opn_wr_n=0 on the same edge, go to WR.
REQ-026 WR: strobe held until the next cen=1 edge, which sets opn_cs_n=1 and opn_wr_n=1 and loads the wait counter with AWAIT (addr=0) or DWAIT (addr=1); enter WAIT, or IDLE if the loaded value is 0.
REQ-027 WAIT: counter decrements on each cen=1 edge; the edge at which it reaches 0 moves to IDLE; a new strobe needs a further cen tick in IDLE.
REQ-028 With cen held at 1, consecutive strobe starts are W+2 clks apart (W = wait value of the earlier write).
REQ-029 Read request latched into a pending flag; further cpu_rd while pending is ignored.
REQ-030 Reads are ordered after writes: IDLE, cen=1, pending set, level==0: drive opn_addr, opn_cs_n=0, opn_wr_n=1; go to RD.
REQ-031 Writes take priority over a pending read whenever level>0 in IDLE.
REQ-032 RD: at the next cen=1 edge, capture opn_dout into cpu_dout, set opn_cs_n=1, pulse cpu_rd_valid for one clk, clear pending, go to IDLE; no recovery wait after reads.
REQ-033 opn_addr/opn_din hold their last driven value while opn_cs_n=1.
REQ-034 cen=0: FSM, wait counter and chip pins frozen; queue push still accepted.

Reset
REQ-035 rst_n=0 takes effect immediately, independent of clk: state IDLE, queue empty, level=0, cpu_full=0, cpu_ovf=0, pending cleared, counter 0.
REQ-036 Outputs during reset: opn_cs_n=1, opn_wr_n=1, opn_addr=0, opn_din=0, cpu_dout=0, cpu_rd_valid=0.
REQ-037 Reset asserted mid-strobe or mid-wait aborts the operation; the queued entry is lost, with no partial strobe after release.

Verification
REQ-038 cen=1, push (0,0x28) then (1,0xF0): address strobe at clk t, data strobe at t+19, opn_cs_n/opn_wr_n low for exactly 1 clk each.
REQ-039 cen=1 every 4th clk, single push (1,0x55): strobe low 4 clks, next strobe not before 4*(1+83+1) clks later.
REQ-040 9 pushes with no drain (cen=0): level=8, cpu_full=1, cpu_ovf=1, 9th entry absent from later strobes.
REQ-041 Push (0,0x07), then cpu_rd with cpu_addr=0 and opn_dout=0xA5: read cycle starts only after AWAIT completes; cpu_dout=0xA5 with a one-clk cpu_rd_valid.
REQ-042 rst_n low during WAIT with 3 entries queued: opn_cs_n=1 immediately, level=0; after release, no strobe without new pushes.
REQ-043 DWAIT=0 with back-to-back data pushes: strobe starts 2 clks apart at cen=1.

Source files
------------

// File: rtl/opn_bus_queue.sv
`default_nettype none
// ============================================================================
// Module      : opn_bus_queue
// Description : CPU-side write queue and bus sequencer for an OPN-style sound
//               chip. CPU writes are buffered in a FIFO and replayed to the
//               chip one at a time, each followed by a recovery wait counted
//               in cen ticks. Reads go out only once the queue has drained.
// Ports       : clk, rst_n (async, active low), cen (chip clock enable)
//               cpu_wr/cpu_rd/cpu_addr/cpu_din  : CPU requests
//               cpu_dout/cpu_rd_valid           : read return
//               cpu_full/cpu_ovf/level          : queue status
//               opn_addr/opn_din/opn_cs_n/opn_wr_n/opn_dout : chip pins
// Revision    : 1.0 - initial release
// ============================================================================
module opn_bus_queue #(
  parameter int DEPTH = 8,
  parameter int AWAIT = 17,
  parameter int DWAIT = 83
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic       cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  output logic       cpu_rd_valid,
  output logic       cpu_full,
  output logic       cpu_ovf,
  output logic [6:0] level,
  output logic       opn_addr,
  output logic [7:0] opn_din,
  output logic       opn_cs_n,
  output logic       opn_wr_n,
  input  logic [7:0] opn_dout
);

  localparam int         PW      = $clog2(DEPTH);
  localparam logic [6:0] DEPTH_L = 7'(DEPTH);
  localparam logic [7:0] AW      = 8'(AWAIT);
  localparam logic [7:0] DW      = 8'(DWAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_WAIT = 2'd2,
    ST_RD   = 2'd3
  } state_t;

  state_t        r_state;
  logic [7:0]    r_cnt;
  logic          r_rd_pend;
  logic          r_rd_addr;

  logic [8:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;

  logic          w_push;
  logic          w_pop;
  logic [8:0]    w_head;
  logic [6:0]    w_level_nxt;
  logic [7:0]    w_wait_val;

  // A full queue drops the write even when a pop frees a slot on the same edge.
  assign w_push     = cpu_wr && (level < DEPTH_L);
  assign w_pop      = cen && (r_state == ST_IDLE) && (level != 7'd0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_wait_val = opn_addr ? DW : AW;

  always_comb begin
    w_level_nxt = level;
    if (w_push && !w_pop) begin
      w_level_nxt = level + 7'd1;
    end else if (!w_push && w_pop) begin
      w_level_nxt = level - 7'd1;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cpu_addr, cpu_din};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      level    <= 7'd0;
      cpu_full <= 1'b0;
      cpu_ovf  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      level    <= w_level_nxt;
      cpu_full <= (w_level_nxt == DEPTH_L);
      if (cpu_wr && !w_push) begin
        cpu_ovf <= 1'b1;
      end
    end
  end

  // Bus sequencer. Everything chip-facing advances only on cen ticks; the
  // read-request latch runs at full clk rate so no request is missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      r_rd_pend    <= 1'b0;
      r_rd_addr    <= 1'b0;
      opn_addr     <= 1'b0;
      opn_din      <= 8'd0;
      opn_cs_n     <= 1'b1;
      opn_wr_n     <= 1'b1;
      cpu_dout     <= 8'd0;
      cpu_rd_valid <= 1'b0;
    end else begin
      cpu_rd_valid <= 1'b0;
      if (cpu_rd && !r_rd_pend) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= cpu_addr;
      end
      if (cen) begin
        case (r_state)
          ST_IDLE: begin
            // Queued writes always win over a pending read.
            if (level != 7'd0) begin
              opn_addr <= w_head[8];
              opn_din  <= w_head[7:0];
              opn_cs_n <= 1'b0;
              opn_wr_n <= 1'b0;
              r_state  <= ST_WR;
            end else if (r_rd_pend) begin
              opn_addr <= r_rd_addr;
              opn_cs_n <= 1'b0;
              opn_wr_n <= 1'b1;
              r_state  <= ST_RD;
            end
          end
          ST_WR: begin
            opn_cs_n <= 1'b1;
            opn_wr_n <= 1'b1;
            r_cnt    <= w_wait_val;
            r_state  <= (w_wait_val == 8'd0) ? ST_IDLE : ST_WAIT;
          end
          ST_WAIT: begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) begin
              r_state <= ST_IDLE;
            end
          end
          ST_RD: begin
            cpu_dout     <= opn_dout;
            opn_cs_n     <= 1'b1;
            cpu_rd_valid <= 1'b1;
            r_rd_pend    <= 1'b0;
            r_state      <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_opn_bus_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_opn_bus_queue
// Description : Self-checking bench for opn_bus_queue. A transaction-level
//               model (queue + busy-tick budget) is compared against the DUT
//               every cycle; directed scenarios add literal timing checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opn_bus_queue;

  localparam int DEPTH = 8;
  localparam int AWAIT = 17;
  localparam int DWAIT = 83;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       cpu_wr = 1'b0;
  logic       cpu_rd = 1'b0;
  logic       cpu_addr = 1'b0;
  logic [7:0] cpu_din = 8'd0;
  logic [7:0] opn_dout = 8'd0;
  logic [7:0] cpu_dout;
  logic       cpu_rd_valid, cpu_full, cpu_ovf;
  logic [6:0] level;
  logic       opn_addr;
  logic [7:0] opn_din;
  logic       opn_cs_n, opn_wr_n;

  logic       wr2 = 1'b0;
  logic       addr2 = 1'b0;
  logic [7:0] din2 = 8'd0;
  logic [7:0] dout2;
  logic       valid2, full2, ovf2;
  logic [6:0] level2;
  logic       opn_addr2;
  logic [7:0] opn_din2;
  logic       cs2_n, wr2_n;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cen_period = 0;
  bit chk_en = 1'b0;

  opn_bus_queue #(.DEPTH(DEPTH), .AWAIT(AWAIT), .DWAIT(DWAIT)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_rd_valid(cpu_rd_valid), .cpu_full(cpu_full),
    .cpu_ovf(cpu_ovf), .level(level),
    .opn_addr(opn_addr), .opn_din(opn_din), .opn_cs_n(opn_cs_n),
    .opn_wr_n(opn_wr_n), .opn_dout(opn_dout)
  );

  opn_bus_queue #(.DEPTH(DEPTH), .AWAIT(AWAIT), .DWAIT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .cpu_wr(wr2), .cpu_rd(1'b0), .cpu_addr(addr2), .cpu_din(din2),
    .cpu_dout(dout2), .cpu_rd_valid(valid2), .cpu_full(full2),
    .cpu_ovf(ovf2), .level(level2),
    .opn_addr(opn_addr2), .opn_din(opn_din2), .opn_cs_n(cs2_n),
    .opn_wr_n(wr2_n), .opn_dout(8'h00)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // cen pattern: 0 = held low, 1 = held high, N = high once every N clks
  initial forever begin
    @(negedge clk);
    if (cen_period == 0)      cen = 1'b0;
    else if (cen_period == 1) cen = 1'b1;
    else                      cen = ((cyc % cen_period) == 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // The chip bus is either free or "busy" for a number of cen ticks: a write
  // costs 1 tick of strobe plus its recovery, a read costs 1 tick of strobe.
  // A free bus can start a new transfer only on a later cen tick.
  logic [8:0] mq[$];
  int         m_busy;
  int         m_sz;
  bit         m_push, m_pend, m_pend_b, m_paddr;
  logic [8:0] m_ent;
  logic       e_cs_n, e_wr_n, e_addr, e_valid, e_ovf;
  logic [7:0] e_din, e_dout;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_busy = 0; m_pend = 0; m_paddr = 0;
      e_cs_n = 1; e_wr_n = 1; e_addr = 0; e_din = 0; e_dout = 0;
      e_valid = 0; e_ovf = 0;
    end else begin
      m_sz     = mq.size();
      m_push   = cpu_wr && (m_sz < DEPTH);
      m_pend_b = m_pend;
      if (cpu_wr && !m_push) e_ovf = 1;
      e_valid = 0;
      if (cen) begin
        if (m_busy > 0) begin
          m_busy--;
          if (e_cs_n == 1'b0) begin
            if (e_wr_n == 1'b1) begin
              e_dout = opn_dout; e_valid = 1; m_pend = 0;
            end
            e_cs_n = 1; e_wr_n = 1;
          end
        end else if (m_sz > 0) begin
          m_ent  = mq.pop_front();
          e_addr = m_ent[8]; e_din = m_ent[7:0];
          e_cs_n = 0; e_wr_n = 0;
          m_busy = (m_ent[8] ? DWAIT : AWAIT) + 1;
        end else if (m_pend_b) begin
          e_addr = m_paddr; e_cs_n = 0; e_wr_n = 1;
          m_busy = 1;
        end
      end
      if (cpu_rd && !m_pend_b) begin m_pend = 1; m_paddr = cpu_addr; end
      if (m_push) mq.push_back({cpu_addr, cpu_din});
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cs_n", opn_cs_n, e_cs_n);
      chk("wr_n", opn_wr_n, e_wr_n);
      chk("opn_addr", opn_addr, e_addr);
      chk("opn_din", opn_din, e_din);
      chk("cpu_dout", cpu_dout, e_dout);
      chk("rd_valid", cpu_rd_valid, e_valid);
      chk("level", level, mq.size());
      chk("full", cpu_full, mq.size() == DEPTH);
      chk("ovf", cpu_ovf, e_ovf);
    end
  end

  // ---------------- bus event recorders ----------------
  int         w_starts[$], w_widths[$], r_starts[$], v_times[$], d2_starts[$];
  logic [8:0] w_data[$], d2_data[$];

  initial begin : mon1
    bit prev_cs = 1'b1;
    bit cur_wr  = 1'b0;
    int low_at  = 0;
    forever begin
      @(negedge clk);
      if (prev_cs && !opn_cs_n) begin
        low_at = cyc;
        cur_wr = !opn_wr_n;
        if (!opn_wr_n) begin
          w_starts.push_back(cyc);
          w_data.push_back({opn_addr, opn_din});
        end else begin
          r_starts.push_back(cyc);
        end
      end
      if (!prev_cs && opn_cs_n && cur_wr) w_widths.push_back(cyc - low_at);
      if (cpu_rd_valid) v_times.push_back(cyc);
      prev_cs = opn_cs_n;
    end
  end

  initial begin : mon2
    bit prev_cs = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_cs && !cs2_n && !wr2_n) begin
        d2_starts.push_back(cyc);
        d2_data.push_back({opn_addr2, opn_din2});
      end
      prev_cs = cs2_n;
    end
  end

  task automatic clear_mon();
    w_starts.delete(); w_widths.delete(); r_starts.delete();
    v_times.delete(); w_data.delete(); d2_starts.delete(); d2_data.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a negedge; leaves the push asserted across one posedge.
  task automatic push(input logic a, input logic [7:0] d);
    cpu_wr = 1'b1; cpu_addr = a; cpu_din = d;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    @(posedge clk);
    chk_en = 1'b1;
    tick(3);
    chk("rst_cs_n", opn_cs_n, 1'b1);
    chk("rst_level", level, 7'd0);
    chk("rst_dout", cpu_dout, 8'h00);
    chk("rst_din", opn_din, 8'h00);
    rst_n = 1'b1;
    cen_period = 1;
    tick(3);

    // ---- address then data write, cen always high ----
    clear_mon();
    push(1'b0, 8'h28);
    push(1'b1, 8'hF0);
    tick(40);
    chk("t1_nstrobes", w_starts.size(), 2);
    if (w_starts.size() == 2 && w_widths.size() == 2) begin
      chk("t1_gap", w_starts[1] - w_starts[0], 19);
      chk("t1_width0", w_widths[0], 1);
      chk("t1_width1", w_widths[1], 1);
      chk("t1_data0", w_data[0], 9'h028);
      chk("t1_data1", w_data[1], 9'h1F0);
    end
    tick(100);

    // ---- cen once every 4 clks ----
    cen_period = 4;
    tick(8);
    clear_mon();
    push(1'b1, 8'h55);
    push(1'b0, 8'h01);
    tick(440);
    chk("t2_nstrobes", w_starts.size(), 2);
    if (w_starts.size() == 2 && w_widths.size() >= 1) begin
      chk("t2_width", w_widths[0], 4);
      chk("t2_gap", w_starts[1] - w_starts[0], 4 * (1 + DWAIT + 1));
    end

    // ---- overflow with the chip frozen ----
    cen_period = 0;
    tick(4);
    clear_mon();
    for (int i = 1; i <= 9; i++) push(1'b0, 8'(i));
    chk("t3_level", level, 7'd8);
    chk("t3_full", cpu_full, 1'b1);
    chk("t3_ovf", cpu_ovf, 1'b1);
    cen_period = 1;
    tick(8 * 19 + 20);
    chk("t3_drained", w_starts.size(), 8);
    if (w_data.size() == 8) chk("t3_last", w_data[7], 9'h008);
    chk("t3_level_end", level, 7'd0);

    // ---- read ordered after a queued write ----
    opn_dout = 8'hA5;
    clear_mon();
    push(1'b0, 8'h07);
    cpu_rd = 1'b1; cpu_addr = 1'b0;
    @(negedge clk);
    cpu_rd = 1'b0;
    tick(30);
    chk("t4_nreads", r_starts.size(), 1);
    chk("t4_nvalid", v_times.size(), 1);
    if (r_starts.size() == 1 && w_starts.size() == 1 && v_times.size() == 1) begin
      chk("t4_rd_after_wait", r_starts[0] - w_starts[0], AWAIT + 2);
      chk("t4_valid_lat", v_times[0] - r_starts[0], 1);
    end
    chk("t4_dout", cpu_dout, 8'hA5);

    // ---- reset in the middle of a recovery wait ----
    push(1'b1, 8'h11);
    push(1'b1, 8'h12);
    push(1'b1, 8'h13);
    push(1'b1, 8'h14);
    tick(10);
    chk("t5_level_pre", level, 7'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_cs_async", opn_cs_n, 1'b1);
    chk("t5_level_async", level, 7'd0);
    tick(3);
    clear_mon();
    rst_n = 1'b1;
    tick(200);
    chk("t5_no_strobe", w_starts.size(), 0);

    // ---- zero data recovery: strobes every 2 clks ----
    clear_mon();
    wr2 = 1'b1; addr2 = 1'b1; din2 = 8'hA1;
    @(negedge clk); din2 = 8'hA2;
    @(negedge clk); din2 = 8'hA3;
    @(negedge clk); wr2 = 1'b0;
    tick(12);
    chk("t6_nstrobes", d2_starts.size(), 3);
    if (d2_starts.size() == 3) begin
      chk("t6_gap0", d2_starts[1] - d2_starts[0], 2);
      chk("t6_gap1", d2_starts[2] - d2_starts[1], 2);
      chk("t6_data2", d2_data[2], 9'h1A3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
